// File: rtl/button_scan_ctrl_pkg.sv
// Shared definitions for the button scan/debounce controller.
// Holds the state encoding, default sizes and a width helper.
package button_scan_pkg;

  localparam logic [1:0] S_SCAN   = 2'd0;
  localparam logic [1:0] S_QUAL   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam int DEF_N_BTN         = 4;
  localparam int DEF_STABLE_CYCLES = 8;

  typedef enum logic [1:0] {
    ST_SCAN   = S_SCAN,
    ST_QUAL   = S_QUAL,
    ST_COMMIT = S_COMMIT
  } scan_state_e;

  // Bits needed to encode values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/button_scan_ctrl_if.sv
// Single-entry press-event port towards the CPU step/run logic.
// The controller drives valid/id, the consumer answers with ready.
interface button_scan_ctrl_if #(
  parameter int ID_W = 2
);

  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_ready;

  modport master (
    output evt_valid,
    output evt_id,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    output evt_ready
  );

endinterface

// File: rtl/button_scan_ctrl_bit_sync2.sv
// Two-flop synchronizer for one asynchronous button input.
module bit_sync2 (
  input  logic clk,
  input  logic nclear,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge nclear) begin
    if (!nclear) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_scan_ctrl.sv
// Round-robin debounce controller: one stability counter shared by all buttons,
// debounced levels, press pulses and a single-slot press event port.
module button_scan_ctrl
  import button_scan_pkg::*;
#(
  parameter int N_BTN         = DEF_N_BTN,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = clog2(STABLE_CYCLES + 1),
  parameter int ID_W          = clog2(N_BTN)
) (
  input  logic              clk,
  input  logic              nclear,
  input  logic [N_BTN-1:0]  bt,
  input  logic              enable,
  output logic [N_BTN-1:0]  level,
  output logic [N_BTN-1:0]  press,
  output logic              overflow,
  output logic              busy,
  button_scan_ctrl_if.master evt
);

  localparam logic [ID_W-1:0]  LAST_IDX   = ID_W'(N_BTN - 1);
  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

  logic [N_BTN-1:0] sync_s;

  for (genvar g = 0; g < N_BTN; g++) begin : g_sync
    bit_sync2 u_sync (
      .clk    (clk),
      .nclear (nclear),
      .d_i    (bt[g]),
      .q_o    (sync_s[g])
    );
  end

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  idx_q, idx_d;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic             evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]  evt_id_q, evt_id_d;
  logic             overflow_q, overflow_d;

  logic            cur_s;
  logic            cur_l;
  logic            load;
  logic [ID_W-1:0] next_idx;

  assign cur_s    = sync_s[idx_q];
  assign cur_l    = level_q[idx_q];
  assign next_idx = (idx_q == LAST_IDX) ? '0 : idx_q + ID_W'(1);

  // The scan state machine: a mismatch on the current button starts the shared
  // counter, any agreeing sample throws the qualification away.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    level_d = level_q;
    press_d = '0;
    load    = 1'b0;
    if (!enable) begin
      state_d = ST_SCAN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_SCAN: begin
          if (cur_s != cur_l) begin
            cnt_d   = CNT_W'(1);
            state_d = ST_QUAL;
          end else begin
            idx_d = next_idx;
          end
        end
        ST_QUAL: begin
          if (cur_s == cur_l) begin
            cnt_d   = '0;
            idx_d   = next_idx;
            state_d = ST_SCAN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q + CNT_W'(1) == STABLE_CNT) begin
              state_d = ST_COMMIT;
            end
          end
        end
        ST_COMMIT: begin
          level_d[idx_q] = ~cur_l;
          cnt_d          = '0;
          idx_d          = next_idx;
          state_d        = ST_SCAN;
          if (!cur_l) begin
            press_d[idx_q] = 1'b1;
            load           = 1'b1;
          end
        end
        default: begin
          state_d = ST_SCAN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A handshake frees the slot in the same cycle, so a simultaneous load still lands.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    overflow_d  = overflow_q;
    if (evt_valid_q && evt.evt_ready) begin
      evt_valid_d = 1'b0;
    end
    if (load) begin
      if (!evt_valid_q || evt.evt_ready) begin
        evt_valid_d = 1'b1;
        evt_id_d    = idx_q;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nclear) begin
    if (!nclear) begin
      state_q     <= ST_SCAN;
      cnt_q       <= '0;
      idx_q       <= '0;
      level_q     <= '0;
      press_q     <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      level_q     <= level_d;
      press_q     <= press_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      overflow_q  <= overflow_d;
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign overflow      = overflow_q;
  assign busy          = (state_q != ST_SCAN);
  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_id    = evt_id_q;

endmodule

// File: tb/tb_button_scan_ctrl.sv
// Self-checking bench for button_scan_ctrl: directed scenarios followed by random
// button activity, all compared cycle by cycle against a behavioural model.
module tb_button_scan_ctrl;

  localparam int N_BTN  = 4;
  localparam int STABLE = 8;
  localparam int ID_W   = 2;

  logic             clk = 1'b0;
  logic             nclear;
  logic [N_BTN-1:0] bt;
  logic             enable;
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] press;
  logic             overflow;
  logic             busy;

  button_scan_ctrl_if #(.ID_W(ID_W)) evtIf ();

  button_scan_ctrl #(
    .N_BTN         (N_BTN),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clk      (clk),
    .nclear   (nclear),
    .bt       (bt),
    .enable   (enable),
    .level    (level),
    .press    (press),
    .overflow (overflow),
    .busy     (busy),
    .evt      (evtIf.master)
  );

  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  // Behavioural model: mRun counts consecutive disagreeing samples of the
  // button under the scan pointer; reaching STABLE means the flip happens next.
  bit [N_BTN-1:0] mS1, mS2, mLevel, mPress;
  int             mIdx, mRun;
  bit             mEvtValid, mOverflow;
  int             mEvtId;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic void modelReset();
    mS1 = '0; mS2 = '0; mLevel = '0; mPress = '0;
    mIdx = 0; mRun = 0;
    mEvtValid = 1'b0; mEvtId = 0; mOverflow = 1'b0;
  endfunction

  function automatic void modelStep(input bit [N_BTN-1:0] btV, input bit en, input bit rdy);
    bit loadEvt;
    int loadId;
    loadEvt = 1'b0;
    loadId  = 0;
    mPress  = '0;
    if (!en) begin
      mRun = 0;
    end else if (mRun == STABLE) begin
      mLevel[mIdx] = ~mLevel[mIdx];
      if (mLevel[mIdx]) begin
        mPress[mIdx] = 1'b1;
        loadEvt      = 1'b1;
        loadId       = mIdx;
      end
      mRun = 0;
      mIdx = (mIdx + 1) % N_BTN;
    end else if (mS2[mIdx] != mLevel[mIdx]) begin
      mRun++;
    end else begin
      mRun = 0;
      mIdx = (mIdx + 1) % N_BTN;
    end
    if (mEvtValid && rdy) mEvtValid = 1'b0;
    if (loadEvt) begin
      if (!mEvtValid) begin
        mEvtValid = 1'b1;
        mEvtId    = loadId;
      end else begin
        mOverflow = 1'b1;
      end
    end
    mS2 = mS1;
    mS1 = btV;
  endfunction

  task automatic checkAll();
    checkOutput("level",    32'(level),           32'(mLevel));
    checkOutput("press",    32'(press),           32'(mPress));
    checkOutput("evtValid", 32'(evtIf.evt_valid), 32'(mEvtValid));
    checkOutput("evtId",    32'(evtIf.evt_id),    32'(mEvtId));
    checkOutput("overflow", 32'(overflow),        32'(mOverflow));
    checkOutput("busy",     32'(busy),            32'(mRun != 0));
  endtask

  task automatic applyStimulus(input logic [N_BTN-1:0] btV, input logic en, input logic rdy);
    bt              = btV;
    enable          = en;
    evtIf.evt_ready = rdy;
    @(posedge clk);
    modelStep(btV, en, rdy);
    #1;
    checkAll();
  endtask

  task automatic doReset();
    bt              = '0;
    evtIf.evt_ready = 1'b0;
    nclear          = 1'b0;
    #2;
    modelReset();
    checkAll();
    checkOutput("rstBusy", 32'(busy), 32'd0);
    #2;
    nclear = 1'b1;
  endtask

  initial begin
    int n;
    int pressSeen;
    int evtSeen;
    logic [N_BTN-1:0] curBt;
    logic curEn;
    logic curRdy;

    nclear          = 1'b0;
    bt              = '0;
    enable          = 1'b1;
    evtIf.evt_ready = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    checkAll();
    #3;
    nclear = 1'b1;

    // Reset in the middle of a qualification.
    n = 0;
    while (mRun < 3 && n < 30) begin
      applyStimulus(4'b0001, 1'b1, 1'b0);
      n++;
    end
    checkOutput("qualReached", 32'(busy), 32'd1);
    doReset();

    // Clean press of button 0, arriving when the scan pointer is on it.
    applyStimulus(4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    n = 0;
    do begin
      applyStimulus(4'b0001, 1'b1, 1'b0);
      n++;
    end while (!level[0] && n < 40);
    checkOutput("pressLatency", 32'(n), 32'd11);
    checkOutput("press0", 32'(press), 32'b0001);
    checkOutput("evt0Valid", 32'(evtIf.evt_valid), 32'd1);
    checkOutput("evt0Id", 32'(evtIf.evt_id), 32'd0);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    checkOutput("pressOneCycle", 32'(press), 32'd0);

    // Bounce on button 2.
    for (int i = 0; i < 5; i++) applyStimulus(4'b0101, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(4'b0001, 1'b1, 1'b0);
    checkOutput("bounceLevel", 32'(level), 32'b0001);
    checkOutput("bounceIdle", 32'(busy), 32'd0);

    // Second press while the slot is full is dropped.
    applyStimulus(4'b0001, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(4'b0011, 1'b1, 1'b0);
    checkOutput("evt1Id", 32'(evtIf.evt_id), 32'd1);
    for (int i = 0; i < 20; i++) applyStimulus(4'b1011, 1'b1, 1'b0);
    checkOutput("dropKeepsId", 32'(evtIf.evt_id), 32'd1);
    checkOutput("dropOverflow", 32'(overflow), 32'd1);

    // Same again, but the consumer accepts in the loading cycle.
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus(4'b0010, 1'b1, 1'b0);
    for (int i = 0; i < 25; i++) begin
      curRdy = (mRun == STABLE && mIdx == 3);
      applyStimulus(4'b1010, 1'b1, curRdy);
    end
    checkOutput("swapId", 32'(evtIf.evt_id), 32'd3);
    checkOutput("swapValid", 32'(evtIf.evt_valid), 32'd1);
    checkOutput("swapOverflow", 32'(overflow), 32'd0);

    // Enable drops four samples into qualifying button 1.
    doReset();
    n = 0;
    while (!(mRun == 4 && mIdx == 1) && n < 40) begin
      applyStimulus(4'b0010, 1'b1, 1'b0);
      n++;
    end
    for (int i = 0; i < 5; i++) applyStimulus(4'b0010, 1'b0, 1'b0);
    checkOutput("abortLevel", 32'(level), 32'd0);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    n = 0;
    do begin
      applyStimulus(4'b0010, 1'b1, 1'b0);
      n++;
    end while (!level[1] && n < 40);
    checkOutput("requalLatency", 32'(n), 32'(STABLE + 1));

    // Release of button 0 after pressing it.
    applyStimulus(4'b0010, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(4'b0011, 1'b1, 1'b0);
    checkOutput("level0Set", 32'(level[0]), 32'd1);
    applyStimulus(4'b0011, 1'b1, 1'b1);
    pressSeen = 0;
    evtSeen   = 0;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(4'b0010, 1'b1, 1'b0);
      if (press != 0) pressSeen++;
      if (evtIf.evt_valid) evtSeen++;
    end
    checkOutput("releaseLevel", 32'(level), 32'b0010);
    checkOutput("releasePress", 32'(pressSeen), 32'd0);
    checkOutput("releaseEvt", 32'(evtSeen), 32'd0);

    // Random activity with bounces, enable gaps, random ready and rare resets.
    curBt = 4'b0010;
    curEn = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N_BTN; i++) begin
        if ($urandom_range(0, 29) == 0) curBt[i] = ~curBt[i];
      end
      if (curEn && $urandom_range(0, 149) == 0) curEn = 1'b0;
      else if (!curEn && $urandom_range(0, 9) == 0) curEn = 1'b1;
      curRdy = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 999) == 0) begin
        doReset();
      end
      applyStimulus(curBt, curEn, curRdy);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
